// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: entry layout, drain FSM states, word offset.
package arm_mem_pkg;

  // Word address starts at this bit; byte offset bits are ignored.
  localparam int unsigned WORD_LSB = 2;

  // Entry fields are sized for the widest supported bus (AW, DW <= 32).
  localparam int unsigned SB_MAX_AW = 32;
  localparam int unsigned SB_MAX_DW = 32;

  typedef struct packed {
    logic [SB_MAX_AW-WORD_LSB-1:0] adr;
    logic [SB_MAX_DW-1:0]          data;
  } sb_entry_t;

  typedef enum logic [0:0] {
    SB_IDLE,
    SB_REQ
  } sb_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core data port plus memory drain/read port of the store buffer.
interface store_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          MemWrite;
  logic          MemRead;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;
  logic          Stall;
  logic          mem_req;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic          mem_ack;
  logic [AW-1:0] mem_rdadr;
  logic [DW-1:0] mem_rd;

  // Buffer side.
  modport slave (
    input  MemWrite, MemRead, DataAdr, WriteData, mem_ack, mem_rd,
    output ReadData, Stall, mem_req, mem_adr, mem_wd, mem_rdadr
  );

  // Core + memory side.
  modport master (
    output MemWrite, MemRead, DataAdr, WriteData, mem_ack, mem_rd,
    input  ReadData, Stall, mem_req, mem_adr, mem_wd, mem_rdadr
  );
endinterface

// File: rtl/store_buffer_sb_match.sv
// Parallel word-address compare of a load against all valid buffer entries.
// Reports a hit and, with STORE_BUFFER_FWD_EN, the youngest matching index.
module sb_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WAW   = 30,
  parameter int unsigned PW    = 2
) (
  input  logic [DEPTH-1:0] valid_i,
  input  logic [WAW-1:0]   entry_adr_i [DEPTH],
  input  logic [PW-1:0]    tail_i,
  input  logic [WAW-1:0]   ld_adr_i,
  output logic             hit_o,
  output logic [PW-1:0]    hit_idx_o
);

  logic [DEPTH-1:0] match;

  // Per-entry equality, masked by occupancy.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_i[i] && (entry_adr_i[i] == ld_adr_i);
    end
    hit_o = |match;
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest (tail-DEPTH .. tail-1) so the youngest hit wins.
  always_comb begin
    hit_idx_o = '0;
    idx       = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - PW'(k);
      if (match[idx]) hit_idx_o = idx;
    end
  end
`else
  logic unused_tail;

  // No forwarding: the index is never consumed.
  always_comb begin
    hit_idx_o   = '0;
    unused_tail = ^tail_i;
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and a variable-latency
// memory. Stores are queued and drained in order over mem_req/mem_ack; loads
// that hit a pending store stall, or are forwarded when STORE_BUFFER_FWD_EN is
// defined. AW and DW must not exceed 32.
module store_buffer
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WAW = AW - WORD_LSB;
  localparam int unsigned EAW = SB_MAX_AW - WORD_LSB;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  sb_entry_t     fifo_q [DEPTH];
  sb_entry_t     fifo_d [DEPTH];
  ptr_t          head_q, head_d, tail_q, tail_d;
  cnt_t          count_q, count_d, count_after_pop;
  sb_state_t     state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;

  logic             full, push, pop;
  sb_entry_t        wr_entry, next_head;
  logic [DEPTH-1:0] valid;
  logic [WAW-1:0]   entry_adr [DEPTH];
  logic [WAW-1:0]   ld_adr;
  logic             hit, ld_req, ld_stall;
  ptr_t             hit_idx;
  logic [DW-1:0]    read_data;

  // Handshake qualification and the entry a store would write.
  always_comb begin
    full          = (count_q == cnt_t'(DEPTH));
    push          = bus.MemWrite && !full;
    pop           = (state_q == SB_REQ) && bus.mem_ack;
    wr_entry.adr  = EAW'(bus.DataAdr[AW-1:WORD_LSB]);
    wr_entry.data = SB_MAX_DW'(bus.WriteData);
    ld_adr        = bus.DataAdr[AW-1:WORD_LSB];
  end

  // Occupancy mask: slot i is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i]     = cnt_t'(ptr_t'(ptr_t'(i) - head_q)) < count_q;
      entry_adr[i] = WAW'(fifo_q[i].adr);
    end
  end

  // FIFO pointer/count update; pointers wrap naturally at DEPTH.
  always_comb begin
    fifo_d          = fifo_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_after_pop = count_q - cnt_t'(pop);
    if (push) begin
      fifo_d[tail_q] = wr_entry;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;
    count_d = count_after_pop + cnt_t'(push);
    // If the queue would be empty but for this push, the new head is the store itself.
    next_head = (count_after_pop == '0) ? wr_entry : fifo_q[head_d];
  end

  // Drain FSM: present head, hold it until ack, then chain the next head bubble-free.
  always_comb begin
    state_d   = state_q;
    mem_adr_d = mem_adr_q;
    mem_wd_d  = mem_wd_q;
    unique case (state_q)
      SB_IDLE: begin
        if (count_d != '0) begin
          state_d   = SB_REQ;
          mem_adr_d = {WAW'(next_head.adr), {WORD_LSB{1'b0}}};
          mem_wd_d  = DW'(next_head.data);
        end
      end
      SB_REQ: begin
        if (pop) begin
          if (count_d != '0) begin
            mem_adr_d = {WAW'(next_head.adr), {WORD_LSB{1'b0}}};
            mem_wd_d  = DW'(next_head.data);
          end else begin
            state_d = SB_IDLE;
          end
        end
      end
      default: state_d = SB_IDLE;
    endcase
    mem_req_d = (state_d == SB_REQ);
  end

  // Control and memory-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= SB_IDLE;
      mem_req_q <= 1'b0;
      mem_adr_q <= '0;
      mem_wd_q  <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_adr_q <= mem_adr_d;
      mem_wd_q  <= mem_wd_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  sb_match #(
    .DEPTH (DEPTH),
    .WAW   (WAW),
    .PW    (PW)
  ) u_sb_match (
    .valid_i     (valid),
    .entry_adr_i (entry_adr),
    .tail_i      (tail_q),
    .ld_adr_i    (ld_adr),
    .hit_o       (hit),
    .hit_idx_o   (hit_idx)
  );

`ifdef STORE_BUFFER_FWD_EN
  // Load path: forward youngest matching store, otherwise memory data.
  always_comb begin
    ld_req    = bus.MemRead && !bus.MemWrite;
    ld_stall  = 1'b0;
    read_data = bus.mem_rd;
    if (ld_req && hit) read_data = DW'(fifo_q[hit_idx].data);
  end
`else
  logic unused_hit_idx;

  // Load path: a hit on any pending store holds the core until it drains.
  always_comb begin
    ld_req         = bus.MemRead && !bus.MemWrite;
    ld_stall       = ld_req && hit;
    read_data      = bus.mem_rd;
    unused_hit_idx = ^hit_idx;
  end
`endif

  assign bus.Stall     = !reset && ((bus.MemWrite && full) || ld_stall);
  assign bus.ReadData  = read_data;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wd    = mem_wd_q;
  assign bus.mem_rdadr = bus.DataAdr;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle ARM core's data port and a variable-latency data memory.
- Stores (MemWrite, DataAdr, WriteData) are accepted in one cycle and drained in order over a req/ack handshake.
- Loads read memory combinationally through a separate read port. A load whose word address matches a pending store is stalled, or forwarded if the optional feature is built.
- The core freezes PC and register writes while Stall=1.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- MemWrite  in  1  core store request (already qualified by CondEx)
- MemRead  in  1  core load request (decoder MemtoReg & CondEx)
- DataAdr  in  AW  core byte address; bits [1:0] ignored (word access only)
- WriteData  in  DW  core store data
- ReadData  out  DW  load data to core
- Stall  out  1  core must hold current instruction
- mem_req  out  1  drain request to memory
- mem_adr  out  AW  drain address (word-aligned, [1:0]=00)
- mem_wd  out  DW  drain data
- mem_ack  in  1  memory accepted current drain write
- mem_rdadr  out  AW  load read address (=DataAdr)
- mem_rd  in  DW  combinational read data for mem_rdadr

Behaviour:
- Storage: circular FIFO of {word adr, data}, DEPTH entries, head/tail pointers plus count (0..DEPTH).
- Reset (synchronous): count=0, pointers=0, state=IDLE. Registered outputs mem_req=0, mem_adr=0, mem_wd=0. Stall is forced 0 while reset=1. Pending entries are discarded. Reset mid-drain abandons the request; mem_req is 0 after the reset edge.
- Push: MemWrite=1 & count<DEPTH → entry written at tail on the clock edge; Stall=0.
- Full: MemWrite=1 & count==DEPTH → Stall=1 combinationally; nothing pushed. This holds even if mem_ack pops in the same cycle. The store is accepted on the next cycle.
- Drain FSM, two states:
  - IDLE: mem_req=0. If count>0 at the edge (including a push this cycle) → REQ, with head loaded into mem_adr/mem_wd and mem_req=1. Minimum latency push→mem_req is 1 cycle.
  - REQ: mem_req, mem_adr, mem_wd are held stable until mem_ack=1. On ack, head is popped.
    - If count-after-pop>0 (including a same-cycle push): stay REQ and present the next head the following cycle. mem_req stays high with no bubble.
    - Otherwise → IDLE.
  - mem_ack while in IDLE is ignored.
- Simultaneous push & pop (count<DEPTH): count unchanged, both pointers advance.
- Pointer wrap-around: modulo DEPTH.
- Load (MemRead=1): DataAdr[AW-1:2] is compared against all valid entries, including the head being drained.
  - No match: ReadData=mem_rd, Stall=0.
  - Match, without the optional feature: Stall=1 until no matching entry remains. ReadData=mem_rd once released.
- MemRead & MemWrite are never both 1; if they are, the store takes priority and the load compare is ignored.
- mem_rdadr=DataAdr always.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN
- Defined: a load match returns the data of the youngest matching entry (closest to tail) in ReadData with Stall=0, same cycle.
- Undefined: a load match stalls until drained (as above). Forwarding mux and priority logic are absent.

Decomposition:
- Package arm_mem_pkg:
  - sb_entry_t typedef struct {adr word, data}
  - sb_state_t enum {SB_IDLE, SB_REQ}
  - localparam WORD_LSB=2
- Sub-module sb_match: parallel address compare over valid entries. Outputs a hit flag and the youngest-hit index (tail-relative priority). Reused by the forward path.

Test Plan:
1. Store 0x64←7, mem_ack=1 constant → mem_req=1 one cycle after push with mem_adr=0x64, mem_wd=7; mem_req=0 next cycle; count=0.
2. DEPTH=4, mem_ack=0, five back-to-back stores to 0x60,0x64,0x68,0x6C,0x70 → Stall=1 on the 5th. Raise ack one cycle → 0x60 drained, 5th accepted next cycle, Stall=0. Drain order is 0x64,0x68,0x6C,0x70.
3. ack=0, stores 0x60←5 then 0x60←9, then load 0x60:
   - With FWD_EN: ReadData=9, Stall=0.
   - Without: Stall=1 until both entries acked, then ReadData=mem_rd.
4. Buffer holds 0x60, load 0x80 with mem_rd=0xDEAD → Stall=0, mem_rdadr=0x80, ReadData=0xDEAD.
5. Buffer full, mem_ack=1 and MemWrite=1 same cycle → Stall=1, count=3 after edge; store pushed next cycle, count=4.
6. Three entries pending, mem_req=1, reset asserted one cycle → after edge: mem_req=0, count=0. A following load to a previously buffered address does not stall.
